// File: rtl/bin2oht_pipe.sv
// bin2oht_pipe: two-stage back-pressured binary to one-hot/thermometer decoder
// ports: i_vld/i_rdy/i_bin/i_thr carry the input beat (i_thr=1 selects thermometer),
//        o_vld/o_rdy/o_oht/o_err carry the decoded beat (o_err flags i_bin >= WIDTH)
module bin2oht_pipe #(
  parameter int WIDTH = 32,
  parameter int SPLIT = $clog2(WIDTH) / 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_vld,
  output logic                     i_rdy,
  input  logic [$clog2(WIDTH)-1:0] i_bin,
  input  logic                     i_thr,
  output logic                     o_vld,
  input  logic                     o_rdy,
  output logic [WIDTH-1:0]         o_oht,
  output logic                     o_err
);
  localparam int WIDTH_LOG = $clog2(WIDTH);
  localparam int GRP = 2 ** SPLIT;
  localparam int NG = (WIDTH + GRP - 1) / GRP;
  if (WIDTH < 2 || SPLIT < 1 || SPLIT > WIDTH_LOG - 1) begin : g_bad_param
    $fatal(1, "bin2oht_pipe: illegal WIDTH/SPLIT");
  end
  logic s1_vld_q, s1_vld_d, thr_q, thr_d, err_q, err_d;
  logic o_vld_q, o_vld_d, o_err_q, o_err_d;
  logic [GRP-1:0] lo_oht_q, lo_oht_d, lo_thr_q, lo_thr_d;
  logic [NG-1:0] hi_oht_q, hi_oht_d, hi_below_q, hi_below_d;
  logic [WIDTH-1:0] oht_n, o_oht_q, o_oht_d;
  logic [SPLIT-1:0] lo;
  logic [WIDTH_LOG-SPLIT-1:0] hi;
  logic s2_adv, accept, load2;
  // only groups holding real output bits are kept; a hi index past them is already an error
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign oht_n[i] = thr_q ? hi_below_q[i/GRP] | (hi_oht_q[i/GRP] & lo_thr_q[i%GRP])
                            : hi_oht_q[i/GRP] & lo_oht_q[i%GRP];
  end
  always_comb begin
    lo = i_bin[SPLIT-1:0];
    hi = i_bin[WIDTH_LOG-1:SPLIT];
    s2_adv = !o_vld_q || o_rdy;
    i_rdy = !rst && (!s1_vld_q || s2_adv);
    accept = i_vld && i_rdy;
    load2 = s2_adv && s1_vld_q;
    s1_vld_d = i_rdy ? i_vld : s1_vld_q;
    lo_oht_d = accept ? GRP'(1) << lo : lo_oht_q;
    // (2<<lo)-1 wraps to all ones for the top lo value
    lo_thr_d = accept ? (GRP'(2) << lo) - GRP'(1) : lo_thr_q;
    hi_oht_d = accept ? NG'(1) << hi : hi_oht_q;
    hi_below_d = accept ? (NG'(1) << hi) - NG'(1) : hi_below_q;
    thr_d = accept ? i_thr : thr_q;
    err_d = accept ? int'(i_bin) >= WIDTH : err_q;
    o_vld_d = s2_adv ? s1_vld_q : o_vld_q;
    o_oht_d = load2 ? (err_q ? '0 : oht_n) : o_oht_q;
    o_err_d = load2 ? err_q : o_err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      lo_oht_q <= '0;
      lo_thr_q <= '0;
      hi_oht_q <= '0;
      hi_below_q <= '0;
      thr_q <= 1'b0;
      err_q <= 1'b0;
      o_vld_q <= 1'b0;
      o_oht_q <= '0;
      o_err_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      lo_oht_q <= lo_oht_d;
      lo_thr_q <= lo_thr_d;
      hi_oht_q <= hi_oht_d;
      hi_below_q <= hi_below_d;
      thr_q <= thr_d;
      err_q <= err_d;
      o_vld_q <= o_vld_d;
      o_oht_q <= o_oht_d;
      o_err_q <= o_err_d;
    end
  end
  assign o_vld = o_vld_q;
  assign o_oht = o_oht_q;
  assign o_err = o_err_q;
endmodule

// File: tb/tb_bin2oht_pipe.sv
// tb_bin2oht_pipe: directed and random checks of bin2oht_pipe across WIDTH/SPLIT variants
module tb_bin2oht_pipe;
  logic clk = 1'b0, rst = 1'b1, i_vld = 1'b0, i_thr = 1'b0, o_rdy = 1'b1;
  logic [4:0] i_bin = '0;
  logic i_rdy, o_vld, o_err;
  logic [31:0] o_oht;
  logic rdy20, vld20, err20;
  logic [19:0] oht20;
  logic rdy_s [3];
  logic vld_s [3];
  logic err_s [3];
  logic [31:0] oht_s [3];
  int total = 0, bad = 0, sent = 0, recv = 0;
  typedef struct {int b; bit t;} beat_t;
  beat_t q[$];
  always #5 clk = ~clk;
  bin2oht_pipe u_w32 (.clk(clk), .rst(rst), .i_vld(i_vld), .i_rdy(i_rdy), .i_bin(i_bin), .i_thr(i_thr),
                      .o_vld(o_vld), .o_rdy(o_rdy), .o_oht(o_oht), .o_err(o_err));
  bin2oht_pipe #(.WIDTH(20)) u_w20 (.clk(clk), .rst(rst), .i_vld(i_vld), .i_rdy(rdy20), .i_bin(i_bin),
                      .i_thr(i_thr), .o_vld(vld20), .o_rdy(o_rdy), .o_oht(oht20), .o_err(err20));
  bin2oht_pipe #(.WIDTH(32), .SPLIT(1)) u_s1 (.clk(clk), .rst(rst), .i_vld(i_vld), .i_rdy(rdy_s[0]), .i_bin(i_bin),
                      .i_thr(i_thr), .o_vld(vld_s[0]), .o_rdy(o_rdy), .o_oht(oht_s[0]), .o_err(err_s[0]));
  bin2oht_pipe #(.WIDTH(32), .SPLIT(3)) u_s3 (.clk(clk), .rst(rst), .i_vld(i_vld), .i_rdy(rdy_s[1]), .i_bin(i_bin),
                      .i_thr(i_thr), .o_vld(vld_s[1]), .o_rdy(o_rdy), .o_oht(oht_s[1]), .o_err(err_s[1]));
  bin2oht_pipe #(.WIDTH(32), .SPLIT(4)) u_s4 (.clk(clk), .rst(rst), .i_vld(i_vld), .i_rdy(rdy_s[2]), .i_bin(i_bin),
                      .i_thr(i_thr), .o_vld(vld_s[2]), .o_rdy(o_rdy), .o_oht(oht_s[2]), .o_err(err_s[2]));
  function automatic logic [31:0] ref_oht(input int w, input int b, input bit t);
    longint v;
    v = (b >= w) ? 64'd0 : t ? (longint'(2) << b) - 1 : longint'(1) << b;
    return v[31:0];
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    beat_t e;
    chk("rdy_agree", {rdy20, rdy_s[0], rdy_s[1], rdy_s[2]}, {4{i_rdy}});
    chk("vld_agree", {vld20, vld_s[0], vld_s[1], vld_s[2]}, {4{o_vld}});
    if (rst) q.delete();
    else begin
      if (o_vld && o_rdy) begin
        chk("sb_extra_beat", 64'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          recv++;
          chk("sb_oht32", o_oht, ref_oht(32, e.b, e.t));
          chk("sb_err32", o_err, 0);
          chk("sb_oht20", oht20, ref_oht(20, e.b, e.t));
          chk("sb_err20", err20, 64'(e.b >= 20));
          for (int s = 0; s < 3; s++) begin
            chk("sb_split_oht", oht_s[s], ref_oht(32, e.b, e.t));
            chk("sb_split_err", err_s[s], 0);
          end
        end
      end
      if (i_vld && i_rdy) begin
        e.b = int'(i_bin);
        e.t = i_thr;
        q.push_back(e);
        sent++;
      end
    end
  end
  task automatic send_chk(input string tag, input int b, input bit t, input logic [31:0] e32,
                          input logic [19:0] e20, input bit ee20);
    bit ok;
    i_vld = 1'b1;
    i_bin = 5'(b);
    i_thr = t;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = i_rdy;
      if (!ok) step();
    end
    chk({tag, "_acc"}, ok, 1);
    step();
    i_vld = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = o_vld;
    end
    chk({tag, "_vld"}, ok, 1);
    chk({tag, "_oht32"}, o_oht, e32);
    chk({tag, "_err32"}, o_err, 0);
    chk({tag, "_oht20"}, oht20, e20);
    chk({tag, "_err20"}, err20, ee20);
    step();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
  initial begin
    int nacc, s0, r0;
    bit acc;
    repeat (3) begin
      @(negedge clk);
      chk("rst_irdy", i_rdy, 0);
      chk("rst_ovld", o_vld, 0);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_irdy", i_rdy, 1);
    chk("post_rst_ovld", o_vld, 0);
    chk("post_rst_oht", o_oht, 0);
    chk("post_rst_err", o_err, 0);
    step();
    for (int n = 0; n <= 34; n++) begin
      i_vld = n < 32;
      i_bin = 5'(n);
      i_thr = 1'b0;
      @(negedge clk);
      chk("stream_vld", o_vld, 64'(n >= 2 && n < 34));
      chk("stream_oht", o_oht, n < 2 ? 64'd0 : 64'(32'(1) << (n >= 33 ? 31 : n - 2)));
      if (n < 32) chk("stream_rdy", i_rdy, 1);
      step();
    end
    send_chk("thr0", 0, 1, 32'h1, 20'h1, 0);
    send_chk("thr5", 5, 1, 32'h3F, 20'h3F, 0);
    send_chk("thr15", 15, 1, 32'hFFFF, 20'hFFFF, 0);
    send_chk("thr31", 31, 1, 32'hFFFF_FFFF, 20'h0, 1);
    send_chk("oh19", 19, 0, 32'h0008_0000, 20'h8_0000, 0);
    send_chk("th19", 19, 1, 32'h000F_FFFF, 20'hF_FFFF, 0);
    send_chk("oh20", 20, 0, 32'h0010_0000, 20'h0, 1);
    send_chk("th20", 20, 1, 32'h001F_FFFF, 20'h0, 1);
    send_chk("oh31", 31, 0, 32'h8000_0000, 20'h0, 1);
    send_chk("oh0", 0, 0, 32'h1, 20'h1, 0);
    o_rdy = 1'b0;
    i_vld = 1'b1;
    i_thr = 1'b0;
    i_bin = 5'd3;
    @(negedge clk);
    chk("bp_rdy_a", i_rdy, 1);
    step();
    i_bin = 5'd7;
    @(negedge clk);
    chk("bp_rdy_b", i_rdy, 1);
    step();
    i_bin = 5'd9;
    repeat (4) begin
      @(negedge clk);
      chk("bp_full_rdy", i_rdy, 0);
      chk("bp_full_vld", o_vld, 1);
      chk("bp_full_oht", o_oht, 32'h8);
      step();
    end
    o_rdy = 1'b1;
    @(negedge clk);
    chk("bp_rel_rdy", i_rdy, 1);
    chk("bp_rel_oht3", o_oht, 32'h8);
    step();
    i_vld = 1'b0;
    @(negedge clk);
    chk("bp_vld7", o_vld, 1);
    chk("bp_oht7", o_oht, 32'h80);
    step();
    @(negedge clk);
    chk("bp_vld9", o_vld, 1);
    chk("bp_oht9", o_oht, 32'h200);
    step();
    @(negedge clk);
    chk("bp_drained", o_vld, 0);
    step();
    o_rdy = 1'b0;
    i_vld = 1'b1;
    i_bin = 5'd12;
    step();
    i_bin = 5'd13;
    step();
    i_vld = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_vld", o_vld, 0);
    chk("mr_oht", o_oht, 0);
    chk("mr_rdy", i_rdy, 1);
    o_rdy = 1'b1;
    repeat (4) begin
      step();
      @(negedge clk);
      chk("mr_quiet", o_vld, 0);
    end
    step();
    s0 = sent;
    r0 = recv;
    nacc = 0;
    acc = 1'b1;
    for (int c = 0; c < 20000 && nacc < 1000; c++) begin
      if (!i_vld || acc) begin
        i_vld = $urandom_range(3) != 0;
        i_bin = 5'($urandom_range(31));
        i_thr = 1'($urandom_range(1));
      end
      o_rdy = $urandom_range(2) != 0;
      @(negedge clk);
      acc = i_vld && i_rdy;
      if (acc) nacc++;
      step();
    end
    i_vld = 1'b0;
    o_rdy = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("rnd_count", nacc, 1000);
    chk("rnd_drain", q.size(), 0);
    chk("rnd_inout", recv - r0, sent - s0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
